// File: rtl/day10_pkg.sv
// Shared day 10 types: reader state encoding and the light/button sizing used by
// the reader, solver and output writer.
package day10_pkg;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int NUM_LIGHTS_MAX  = 10;
  localparam int NUM_BUTTONS_MAX = 16;
  localparam int NUM_LIGHTS_W    = cnt_w(NUM_LIGHTS_MAX);
  localparam int NUM_BUTTONS_W   = cnt_w(NUM_BUTTONS_MAX);

  typedef enum logic [2:0] {
    INIT,
    HDR_LIGHTS,
    HDR_BUTTONS,
    TARGET,
    BUTTONS,
    READY,
    ERROR
  } reader_state_e;

endpackage

// File: rtl/axi_stream_if.sv
// Byte-oriented AXI-Stream link: valid/ready handshake with an end-of-record tlast.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/day10_input_if.sv
// One parsed machine record: counts, target light pattern and per-button masks.
interface day10_input_if #(
  parameter int MAX_NUM_LIGHTS  = 10,
  parameter int MAX_NUM_BUTTONS = 16
);
  localparam int LIGHTS_W  = day10_pkg::cnt_w(MAX_NUM_LIGHTS);
  localparam int BUTTONS_W = day10_pkg::cnt_w(MAX_NUM_BUTTONS);

  logic [LIGHTS_W-1:0]                             num_lights;
  logic [BUTTONS_W-1:0]                            num_buttons;
  logic [MAX_NUM_LIGHTS-1:0]                       target_lights;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  buttons;

  modport producer (output num_lights, output num_buttons, output target_lights, output buttons);
  modport consumer (input num_lights, input num_buttons, input target_lights, input buttons);
endinterface

// File: rtl/axi_read_vector.sv
// Loads one LSB-first bit vector of vec_length bits; ready with the final beat's handshake (comb).
// Owns tready while busy; a zero-length vector completes in its first cycle without a beat.
module axi_read_vector
  import day10_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int VEC_W          = 10,
  parameter int LEN_W          = cnt_w(VEC_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      clear,
  input  logic [LEN_W-1:0]          vec_length,
  input  logic                      tvalid,
  input  logic [AXI_DATA_WIDTH-1:0] tdata,
  output logic                      tready,
  output logic [VEC_W-1:0]          vec,
  output logic                      ready
);

  localparam int MAX_BEATS = (VEC_W + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
  localparam int BEAT_W    = cnt_w(MAX_BEATS);

  logic              busy_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] nbeats_q;
  logic [LEN_W-1:0]  len_q;
  logic [VEC_W-1:0]  vec_q;
  logic [VEC_W-1:0]  vec_merged;
  logic              hs;
  logic              last_beat;

  assign tready    = busy_q && (nbeats_q != '0);
  assign hs        = tready && tvalid;
  assign last_beat = (beat_q == nbeats_q - BEAT_W'(1));
  assign ready     = busy_q && ((nbeats_q == '0) || (hs && last_beat));
  assign vec       = hs ? vec_merged : vec_q;

  // Bits at or above the vector length never leave the reset value of 0.
  always_comb begin
    vec_merged = vec_q;
    for (int i = 0; i < VEC_W; i++) begin
      if ((int'(beat_q) == i / AXI_DATA_WIDTH) && (i < int'(len_q)))
        vec_merged[i] = tdata[i % AXI_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      busy_q   <= 1'b0;
      beat_q   <= '0;
      nbeats_q <= '0;
      len_q    <= '0;
      vec_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      beat_q   <= '0;
      nbeats_q <= BEAT_W'((int'(vec_length) + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH);
      len_q    <= vec_length;
      vec_q    <= '0;
    end else if (ready) begin
      busy_q <= 1'b0;
    end else if (hs) begin
      beat_q <= beat_q + BEAT_W'(1);
      vec_q  <= vec_merged;
    end
  end

endmodule

// File: rtl/day10_input_reader.sv
// Parses one day 10 machine record per start; reader_ready pulses the cycle after the final beat.
// One beat per cycle, tready only in parse states; DAY10_INPUT_READER_CHECK_EN adds record checks.
module day10_input_reader
  import day10_pkg::*;
#(
  parameter int MAX_NUM_LIGHTS  = NUM_LIGHTS_MAX,
  parameter int MAX_NUM_BUTTONS = NUM_BUTTONS_MAX,
  parameter int AXI_DATA_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    reader_ready,
  output logic                    last_input,
  output logic                    input_error,
  axi_stream_if.slave             data_in,
  day10_input_if.producer         day10_input
);

  localparam int MAX_NUM_LIGHTS_W  = cnt_w(MAX_NUM_LIGHTS);
  localparam int MAX_NUM_BUTTONS_W = cnt_w(MAX_NUM_BUTTONS);

  reader_state_e state_q, state_d;

  logic [MAX_NUM_LIGHTS_W-1:0]                    num_lights_q;
  logic [MAX_NUM_BUTTONS_W-1:0]                   num_buttons_q;
  logic [MAX_NUM_BUTTONS_W-1:0]                   btn_cnt_q;
  logic [MAX_NUM_LIGHTS-1:0]                      target_q;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons_q;
  logic                                           last_input_q;

  logic                      tready_int;
  logic                      hs;
  logic                      vec_start;
  logic                      vec_clear;
  logic                      vec_tready;
  logic                      vec_ready;
  logic [MAX_NUM_LIGHTS-1:0] vec;
  logic                      last_btn;
  logic                      rec_err;

  assign hs       = data_in.tvalid && tready_int;
  assign last_btn = (btn_cnt_q == num_buttons_q - MAX_NUM_BUTTONS_W'(1));

  axi_read_vector #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .VEC_W          (MAX_NUM_LIGHTS),
    .LEN_W          (MAX_NUM_LIGHTS_W)
  ) u_read_vec (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (vec_start),
    .clear      (vec_clear),
    .vec_length (num_lights_q),
    .tvalid     (data_in.tvalid),
    .tdata      (data_in.tdata),
    .tready     (vec_tready),
    .vec        (vec),
    .ready      (vec_ready)
  );

`ifdef DAY10_INPUT_READER_CHECK_EN
  logic is_final;
  logic in_parse;
  logic err_tlast_q;
  logic input_error_q;

  // The record's final beat is the last header beat when there are no lights.
  always_comb begin
    is_final = 1'b0;
    case (state_q)
      HDR_BUTTONS: is_final = (num_lights_q == '0);
      TARGET:      is_final = vec_ready && (num_buttons_q == '0);
      BUTTONS:     is_final = vec_ready && last_btn;
      default:     is_final = 1'b0;
    endcase
  end

  assign in_parse = (state_q == HDR_LIGHTS) || (state_q == HDR_BUTTONS) ||
                    (state_q == TARGET) || (state_q == BUTTONS);

  always_comb begin
    rec_err = 1'b0;
    if (hs && in_parse) begin
      rec_err = (data_in.tlast != is_final);
      if ((state_q == HDR_LIGHTS) && (int'(data_in.tdata[6:0]) > MAX_NUM_LIGHTS))
        rec_err = 1'b1;
      if ((state_q == HDR_BUTTONS) && (int'(data_in.tdata[7:0]) > MAX_NUM_BUTTONS))
        rec_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_tlast_q   <= 1'b0;
      input_error_q <= 1'b0;
    end else begin
      input_error_q <= (state_q == ERROR) && (state_d == INIT);
      if (rec_err)
        err_tlast_q <= data_in.tlast;
      else if (state_q == INIT)
        err_tlast_q <= 1'b0;
    end
  end

  assign vec_clear   = (state_q == ERROR);
  assign input_error = input_error_q;
`else
  logic unused_tlast;
  assign unused_tlast = data_in.tlast;
  assign rec_err      = 1'b0;
  assign vec_clear    = 1'b0;
  assign input_error  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:        if (start) state_d = HDR_LIGHTS;
      HDR_LIGHTS:  if (hs) state_d = HDR_BUTTONS;
      HDR_BUTTONS: if (hs) state_d = TARGET;
      TARGET:      if (vec_ready) state_d = (num_buttons_q == '0) ? READY : BUTTONS;
      BUTTONS:     if (vec_ready && last_btn) state_d = READY;
      READY:       state_d = INIT;
`ifdef DAY10_INPUT_READER_CHECK_EN
      ERROR:       if (err_tlast_q || (hs && data_in.tlast)) state_d = INIT;
`endif
      default:     state_d = INIT;
    endcase
    if (rec_err) state_d = ERROR;
  end

  always_comb begin
    tready_int   = 1'b0;
    reader_ready = 1'b0;
    case (state_q)
      HDR_LIGHTS,
      HDR_BUTTONS: tready_int = 1'b1;
      TARGET,
      BUTTONS:     tready_int = vec_tready;
      READY:       reader_ready = 1'b1;
`ifdef DAY10_INPUT_READER_CHECK_EN
      ERROR:       tready_int = !err_tlast_q;
`endif
      default:     tready_int = 1'b0;
    endcase
  end

  // Next vector load is armed in the same cycle the previous one completes, so beats stay back-to-back.
  always_comb begin
    vec_start = 1'b0;
    if (!rec_err) begin
      case (state_q)
        HDR_BUTTONS: vec_start = hs;
        TARGET:      vec_start = vec_ready && (num_buttons_q != '0);
        BUTTONS:     vec_start = vec_ready && !last_btn;
        default:     vec_start = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_lights_q  <= '0;
      num_buttons_q <= '0;
      btn_cnt_q     <= '0;
      target_q      <= '0;
      buttons_q     <= '0;
      last_input_q  <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (start) begin
            num_lights_q  <= '0;
            num_buttons_q <= '0;
            btn_cnt_q     <= '0;
            target_q      <= '0;
            buttons_q     <= '0;
            last_input_q  <= 1'b0;
          end
        end
        HDR_LIGHTS: begin
          if (hs) begin
            last_input_q <= data_in.tdata[7];
            num_lights_q <= data_in.tdata[MAX_NUM_LIGHTS_W-1:0];
          end
        end
        HDR_BUTTONS: begin
          if (hs) num_buttons_q <= data_in.tdata[MAX_NUM_BUTTONS_W-1:0];
        end
        TARGET: begin
          if (vec_ready) target_q <= vec;
        end
        BUTTONS: begin
          if (vec_ready) begin
            for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
              if (btn_cnt_q == MAX_NUM_BUTTONS_W'(b)) buttons_q[b] <= vec;
            end
            btn_cnt_q <= btn_cnt_q + MAX_NUM_BUTTONS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign data_in.tready            = tready_int;
  assign last_input                = last_input_q;
  assign day10_input.num_lights    = num_lights_q;
  assign day10_input.num_buttons   = num_buttons_q;
  assign day10_input.target_lights = target_q;
  assign day10_input.buttons       = buttons_q;

endmodule
